// File: rtl/mux_l2_pkg.sv
// rtl/mux_l2_pkg.sv - shared constants, lane encoding and clog2 helper for the layer-2 2x1 interleaver
package mux_l2_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// rtl/fifo_lane.sv - per-lane synchronous FIFO with pop-frees-slot push acceptance and drop flag
module fifo_lane
    import mux_l2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    // Status flags and accept/drop decisions; a same-edge pop makes room for the push.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
        dout    = mem[rd_ptr];
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy counter, 0..DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mux_l2_2x1.sv
// rtl/mux_l2_2x1.sv - two-lane to one-stream byte interleaver; MUXL2_STATS_EN adds an output byte counter
module mux_l2_2x1
    import mux_l2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Entrada0,
    input  logic              validEntrada0,
    input  logic [DATA_W-1:0] Entrada1,
    input  logic              validEntrada1,
    output logic [DATA_W-1:0] Salida_conductual,
    output logic              validsalida,
    output logic              overflow0,
    output logic              overflow1
`ifdef MUXL2_STATS_EN
    ,
    output logic [15:0]       conteo_bytes
`endif
);

    lane_e             sel;
    lane_e             sel_next;
    logic              pop0;
    logic              pop1;
    logic              take;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] dout0;
    logic [DATA_W-1:0] dout1;
    logic              empty0;
    logic              empty1;
    logic              full0;
    logic              full1;
    logic              drop0;
    logic              drop1;

    fifo_lane #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (validEntrada0),
        .din   (Entrada0),
        .pop   (pop0),
        .dout  (dout0),
        .empty (empty0),
        .full  (full0),
        .drop  (drop0)
    );

    fifo_lane #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (validEntrada1),
        .din   (Entrada1),
        .pop   (pop1),
        .dout  (dout1),
        .empty (empty1),
        .full  (full1),
        .drop  (drop1)
    );

    // Lane selector state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= LANE0;
        end else begin
            sel <= sel_next;
        end
    end

    // Advance to the other lane only after serving the expected one; never skip.
    always_comb begin
        sel_next = sel;
        if (take) begin
            sel_next = (sel == LANE0) ? LANE1 : LANE0;
        end
    end

    // Pop the selected lane when it holds data and pick its head byte.
    always_comb begin
        pop0 = (sel == LANE0) && !empty0;
        pop1 = (sel == LANE1) && !empty1;
        take = pop0 || pop1;
        head = (sel == LANE0) ? dout0 : dout1;
    end

    // Registered output byte; forced to zero on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            Salida_conductual <= '0;
            validsalida       <= 1'b0;
        end else begin
            Salida_conductual <= take ? head : '0;
            validsalida       <= take;
        end
    end

    // Sticky drop indicators, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow0 <= 1'b0;
            overflow1 <= 1'b0;
        end else begin
            overflow0 <= overflow0 | drop0;
            overflow1 <= overflow1 | drop1;
        end
    end

`ifdef MUXL2_STATS_EN
    logic [15:0] stat_count;

    // Saturating count of emitted bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_count <= '0;
        end else if (take && (stat_count != 16'hFFFF)) begin
            stat_count <= stat_count + 16'd1;
        end
    end

    assign conteo_bytes = stat_count;
`else
    logic unused_full;
    assign unused_full = full0 ^ full1;
`endif

`ifdef MUXL2_STATS_EN
    logic unused_full;
    assign unused_full = full0 ^ full1;
`endif

endmodule

// File: doc/mux_l2_2x1.md
Name: mux_l2_2x1

Overview:
- Two-lane to one-stream interleaver; inverse of the layer-2 1x2 byte demux.
- Byte stream was split round-robin: byte 0 to lane 0, byte 1 to lane 1, byte 2 to lane 0, and so on. This block buffers each lane and re-serialises strictly alternating, starting at lane 0, to restore the original order.
- Sits on the receive-side reassembly path, in the same clock domain as the layer-2 demux.

Parameters:
- DATA_W, 8, byte width of every lane and of the output.
- DEPTH, 4, entries per lane FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Entrada0  input  DATA_W  lane 0 byte.
- validEntrada0  input  1  lane 0 byte valid; sampled each clk edge.
- Entrada1  input  DATA_W  lane 1 byte.
- validEntrada1  input  1  lane 1 byte valid.
- Salida_conductual  output  DATA_W  reassembled byte, registered.
- validsalida  output  1  Salida_conductual valid, registered.
- overflow0  output  1  sticky; a lane 0 byte was dropped because its FIFO was full.
- overflow1  output  1  sticky; same for lane 1.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - Salida_conductual = 0, validsalida = 0, overflow0/1 = 0.
  - Both FIFOs are emptied (pointers = 0, count = 0).
  - Lane selector sel = 0.
- Reset mid-operation discards all buffered bytes. Inputs presented in the reset cycle are ignored.
- Lane FIFO push: on an edge with validEntradaX = 1, the byte is written to FIFO X.
- Full FIFO: if FIFO X holds DEPTH entries and no pop of X happens on that edge, the byte is dropped and overflowX is set to 1. overflowX stays 1 until reset.
- Push and pop of the same FIFO on the same edge are both legal when full: the pop frees a slot, so the push succeeds with no overflow.
- Output state machine, states LANE0 and LANE1 (= sel):
  - If FIFO[sel] is non-empty (count before this edge > 0): pop its head, register it on Salida_conductual, set validsalida = 1, toggle sel.
  - Else: validsalida = 0, Salida_conductual = 0, sel unchanged. The block waits for the expected lane and never skips to the other lane, so order is preserved.
- Latency: a byte pushed at edge k into an empty, currently selected FIFO appears on the outputs after edge k+1. There is no same-edge bypass.
- Throughput: one byte per clock sustained when both lanes supply one byte per two clocks each.
- Pointers wrap modulo DEPTH. count has width clog2(DEPTH)+1 and ranges 0..DEPTH.
- A lane 1 byte arriving before its lane 0 partner is held until lane 0 has been served.

Optional Feature:
- Macro: MUXL2_STATS_EN.
- Defined: adds output port conteo_bytes [15:0], reset to 0. It increments on every edge where validsalida is set to 1 and saturates at 16'hFFFF; it does not wrap.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mux_l2_pkg holds:
  - DATA_W_DEF = 8 and DEPTH_DEF = 4;
  - lane-select encoding LANE0 = 1'b0, LANE1 = 1'b1;
  - a clog2 helper function.
- Sub-module fifo_lane: synchronous FIFO parameterised by DATA_W and DEPTH.
  - Ports: clk, reset, push, din, pop, dout, empty, full, drop.
  - Instantiated twice. Arbitration, output registers and overflow/stats logic stay in mux_l2_2x1.

Test Plan:
- Order restore: feed lane 0 = 0x10, 0x12, 0x14 and lane 1 = 0x11, 0x13, 0x15, one valid pair every 2 clocks → output 0x10..0x15 in order. Each validsalida pulse is 1 cycle; first byte appears 1 clock after the first push.
- Lane skew: push lane 1 = 0xB1 three clocks before lane 0 = 0xA0 → validsalida stays 0 until 0xA0 arrives. Output is then 0xA0 followed by 0xB1 on the next clock.
- Overflow: hold lane 1 empty and push 6 bytes 0x01..0x06 into lane 0 (DEPTH = 4) → 0x01 is output, sel then waits on lane 1, FIFO 0 holds 0x02..0x05, and 0x06 is dropped. overflow0 goes to 1 and stays 1; overflow1 stays 0.
- Full with simultaneous pop: FIFO 0 full, sel = 0, push 0x77 on lane 0 on the same edge as the pop → no overflow, and 0x77 is emitted in order later.
- Reset mid-stream: assert reset for 1 clock with 3 bytes buffered → next cycle all outputs are 0 and the FIFOs are empty. A new pair 0x55/0x66 then emits as 0x55, 0x66, confirming sel restarts at lane 0.
- MUXL2_STATS_EN: stream 10 bytes → conteo_bytes = 10. Force the counter to 16'hFFFE and emit 3 bytes → conteo_bytes = 16'hFFFF.
